// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg
//   Shared definitions for the sequential shift-add multiplier.
//   - 2-bit controller state type with its fixed encoding
//     (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
// ---------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : seq_mul_pkg

// File: rtl/seq_mul_step.sv
// ---------------------------------------------------------------------------
// seq_mul_step
//   Combinational single shift-add step of the sequential multiplier.
//   Ports:
//     acc_a_i / acc_a_o  2*WIDTH  shifted multiplicand in / out (logical << 1)
//     acc_b_i / acc_b_o  WIDTH    remaining multiplier bits in / out (logical >> 1)
//     sum_i   / sum_o    2*WIDTH  partial product in / out (+acc_a when acc_b[0])
// ---------------------------------------------------------------------------
module seq_mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_a_i,
    input  logic [WIDTH-1:0]   acc_b_i,
    input  logic [2*WIDTH-1:0] sum_i,
    output logic [2*WIDTH-1:0] acc_a_o,
    output logic [WIDTH-1:0]   acc_b_o,
    output logic [2*WIDTH-1:0] sum_o
);

    assign sum_o   = acc_b_i[0] ? (sum_i + acc_a_i) : sum_i;
    assign acc_a_o = acc_a_i << 1;
    assign acc_b_o = acc_b_i >> 1;

endmodule : seq_mul_step

// File: rtl/seq_mul.sv
// ---------------------------------------------------------------------------
// seq_mul
//   Multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one operation
//   in flight. Result appears exactly WIDTH clocks after operand acceptance.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | in_ready=1, waiting for operands
//   RUN     | WIDTH shift-add steps, inputs ignored
//   DONE    | out_valid=1, product held until out_ready/abort
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     in_valid / in_ready    operand handshake (a, b, sgn)
//     a, b       WIDTH-bit multiplicand / multiplier
//     sgn        two's-complement mode (only with SEQ_MUL_SIGNED_EN)
//     abort      synchronous abort of RUN/DONE, no effect in IDLE
//     out_valid / out_ready  result handshake
//     product    2*WIDTH-bit result
//
//   Build option: SEQ_MUL_SIGNED_EN adds the sgn port and signed operation.
// ---------------------------------------------------------------------------
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                 sgn,
`endif
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q,   state_d;
    logic [2*WIDTH-1:0]   acc_a_q,   acc_a_d;
    logic [WIDTH-1:0]     acc_b_q,   acc_b_d;
    logic [2*WIDTH-1:0]   sum_q,     sum_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 neg_q,     neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;

    logic [2*WIDTH-1:0]   step_acc_a;
    logic [WIDTH-1:0]     step_acc_b;
    logic [2*WIDTH-1:0]   step_sum;

`ifdef SEQ_MUL_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a  = (sgn && a[WIDTH-1]) ? (~a + ONE_W) : a;
        mag_b  = (sgn && b[WIDTH-1]) ? (~b + ONE_W) : b;
        neg_in = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    assign mag_a  = a;
    assign mag_b  = b;
    assign neg_in = 1'b0;
`endif

    seq_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_a_i (acc_a_q),
        .acc_b_i (acc_b_q),
        .sum_i   (sum_q),
        .acc_a_o (step_acc_a),
        .acc_b_o (step_acc_b),
        .sum_o   (step_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_a_d = {{WIDTH{1'b0}}, mag_a};
                    acc_b_d = mag_b;
                    sum_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    neg_d   = neg_in;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_a_d = step_acc_a;
                    acc_b_d = step_acc_b;
                    sum_d   = step_sum;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        product_d = neg_q ? (~step_sum + ONE_P) : step_sum;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // abort takes priority over a same-cycle out_ready
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign product = product_q;

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_seq_mul
//   Directed self-checking bench for seq_mul: an 8-bit and a 16-bit instance
//   sharing clock and reset. Signed vectors are included when
//   SEQ_MUL_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_mul;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, abort, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] product;
`ifdef SEQ_MUL_SIGNED_EN
    logic        sgn;
`endif

    logic        in_valid_w, in_ready_w, abort_w, out_valid_w, out_ready_w;
    logic [15:0] a_w, b_w;
    logic [31:0] product_w;
`ifdef SEQ_MUL_SIGNED_EN
    logic        sgn_w;
`endif

    int n_vec;
    int n_err;

    seq_mul #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn       (sgn),
`endif
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    seq_mul #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .a         (a_w),
        .b         (b_w),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn       (sgn_w),
`endif
        .abort     (abort_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .product   (product_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where out_valid rose.
    task automatic run8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic s, input logic [15:0] exp);
        int n;
        int lat;
        a = ai;
        b = bi;
`ifdef SEQ_MUL_SIGNED_EN
        sgn = s;
`else
        if (s) $display("note: signed vector %s run unsigned", tag);
`endif
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 0;
        chk({tag, "_latency"}, 64'(lat - 1), 64'd8);
        chk({tag, "_product"}, 64'(product), 64'(exp));
    endtask

    task automatic run16(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                         input logic [31:0] exp);
        int n;
        int lat;
        a_w = ai;
        b_w = bi;
        in_valid_w = 1'b1;
        n = 0;
        while (!in_ready_w && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        lat = 1;
        while (!out_valid_w && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_w) lat = 0;
        chk({tag, "_latency"}, 64'(lat - 1), 64'd16);
        chk({tag, "_product"}, 64'(product_w), 64'(exp));
    endtask

    initial begin
        int lat;
        logic seen;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; abort = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; a_w = '0; b_w = '0; abort_w = 1'b0; out_ready_w = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
        sgn = 1'b0;
        sgn_w = 1'b0;
`endif
        #23;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_product_w", 64'(product_w), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full-scale unsigned
        run8("u8_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);

        // back-pressure: result held while out_ready low
        @(posedge clk); #1;
        out_ready = 1'b0;
        run8("stall_12x10", 8'd12, 8'd10, 1'b0, 16'd120);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_product", 64'(product), 64'd120);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);

        // abort during RUN step 3
        a = 8'd9; b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_product_stale", 64'(product), 64'd120);
        run8("after_abort_3x7", 8'd3, 8'd7, 1'b0, 16'd21);
        @(posedge clk); #1;

        // asynchronous reset in the middle of RUN, away from an edge
        a = 8'd200; b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_product", 64'(product), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run8("after_rst_5x5", 8'd5, 8'd5, 1'b0, 16'd25);
        @(posedge clk); #1;

        // abort in IDLE does not block acceptance; in_valid during RUN ignored,
        // then held operands are taken once the block is idle again
        a = 8'd4; b = 8'd6; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_accepted", 64'(in_ready), 64'd0);
        a = 8'd1; b = 8'd1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held_latency", 64'(lat), 64'd8);
        chk("held_product", 64'(product), 64'd24);
        @(posedge clk); #1;
        chk("held_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held_second_accept", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("second_latency", 64'(lat), 64'd8);
        chk("second_product", 64'(product), 64'd1);
        @(posedge clk); #1;

        // 16-bit instance
        run16("u16_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        @(posedge clk); #1;
        run16("u16_a0", 16'h0000, 16'h1234, 32'h0);
        @(posedge clk); #1;
        run16("u16_b0", 16'h1234, 16'h0000, 32'h0);
        @(posedge clk); #1;
        run16("u16_mix", 16'h1234, 16'h0010, 32'h00012340);
        @(posedge clk); #1;

`ifdef SEQ_MUL_SIGNED_EN
        run8("s8_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
        @(posedge clk); #1;
        run8("s8_m1_127", 8'hFF, 8'h7F, 1'b1, 16'hFF81);
        @(posedge clk); #1;
        run8("s8_u_ff_7f", 8'hFF, 8'h7F, 1'b0, 16'h7E81);
        @(posedge clk); #1;
        run8("s8_m3_5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_mul
